alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised successor of the single-cycle datapath ALU.
- Adds registered outputs, a Start/Busy/Done handshake, iterative multiply (full 2×WIDTH product) and iterative unsigned divide/remainder.
- Sits in the execute stage of the multi-cycle core. The control FSM stalls while Busy=1.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only when Busy=0.
- SrcA  input  WIDTH  operand A (latched on accept).
- SrcB  input  WIDTH  operand B (latched on accept).
- ALUControl  input  3  operation select (latched on accept).
- ALUResult  output  WIDTH  registered result (low word / quotient / remainder).
- ALUResultHi  output  WIDTH  high word of MUL product; 0 for all other ops.
- Zero  output  1  ALUResult == 0 (combinational from the ALUResult register).
- Busy  output  1  iterative op in progress.
- Done  output  1  one-cycle pulse, result valid.
- DivByZero  output  1  registered flag, set by DIVU/REMU with SrcB==0.

Behaviour:
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 DIVU
  - 100 SUB
  - 101 MUL
  - 110 SLTU (result 1 or 0, unsigned compare)
  - 111 REMU
- ADD, SUB and MUL wrap modulo 2^WIDTH for the low word. No overflow flag.
- Reset (RST=0, async):
  - State=IDLE.
  - ALUResult, ALUResultHi, Busy, Done, DivByZero and the counter all =0.
  - Zero=1.
- State machine IDLE → CALC → IDLE. No other states.
- IDLE, Start=1 at edge N (accept):
  - Operands and opcode are latched. DivByZero is cleared unless set by this op.
  - Single-cycle ops (AND/OR/ADD/SUB/SLTU): result written at edge N. Done=1 for the cycle after edge N. State stays IDLE. Back-to-back Starts are accepted every cycle.
  - DIVU/REMU with SrcB==0: handled in one cycle.
    - DIVU → ALUResult = all-ones. REMU → ALUResult = SrcA.
    - DivByZero=1, Done=1 after edge N. No CALC entry.
  - MUL/DIVU/REMU otherwise: Busy=1 after edge N. State=CALC, counter=0.
- CALC:
  - One iteration per edge at N+1 … N+WIDTH.
  - MUL: shift-add, one multiplier bit per edge, LSB first.
  - DIVU/REMU: restoring, one quotient bit per edge, MSB first.
- On edge N+WIDTH:
  - Final result is written. Busy=0, Done=1 for one cycle, state=IDLE.
  - Iterative latency is exactly WIDTH cycles from the accept edge.
- Start while Busy=1 is ignored. No queueing, and no effect on in-flight operands.
- Start on the same edge that Busy falls (edge N+WIDTH) is ignored. The next accept is possible at edge N+WIDTH+1.
- ALUResult, ALUResultHi and DivByZero hold their value until the next write. Done does not.
- Input changes on SrcA/SrcB/ALUControl after accept have no effect.
- Reset mid-CALC aborts immediately:
  - All outputs take their reset values.
  - No Done pulse is issued for the aborted operation.
- Internal: WIDTH-bit partial-product/remainder register, WIDTH-bit shift register, CNT_W counter.

Optional Feature:
- Macro: ALU_EARLY_TERM_EN.
- Defined:
  - MUL finishes at the first edge on which the remaining unshifted multiplier bits are all zero (minimum 1 iteration). Counter effects are ignored in that case.
  - The result is written and Done is pulsed on that edge.
  - MUL with SrcB==0 completes at edge N+1.
  - DIVU/REMU latency is unchanged (WIDTH).
- Undefined: MUL always takes exactly WIDTH cycles.
- The product value is identical in both builds.

Test Plan:
1. Reset mid-MUL: reset released, Start MUL 5×7, assert RST=0 at iteration 10 → Busy=0, ALUResult=0, Zero=1, no Done pulse. After release, Start ADD 3+4 → Done after 1 cycle, ALUResult=7, Zero=0.
2. Single-cycle ops, WIDTH=32:
   - SUB 5−5 → ALUResult=0, Zero=1.
   - SLTU 0xFFFFFFFF vs 1 → 0.
   - Back-to-back AND 0xF0F0F0F0&0xFF00FF00 then OR of the same operands → Done on consecutive cycles; results 0xF000F000 then 0xFFF0FFF0.
3. MUL 0xFFFFFFFF×0xFFFFFFFF:
   - Busy for 32 cycles.
   - Done at accept+32.
   - ALUResultHi=0xFFFFFFFE, ALUResult=0x00000001.
   - A Start pulsed at cycle 10 is ignored (operands unchanged).
4. DIVU 100/7 → 14 and REMU 100/7 → 2, each Done at accept+32, DivByZero=0.
5. DIVU 9/0 → ALUResult=0xFFFFFFFF, DivByZero=1, Done at accept+1. REMU 9/0 → 9.
6. ALU_EARLY_TERM_EN:
   - Defined: MUL 3×5 → Done at accept+3, ALUResult=15. MUL 3×0 → Done at accept+1, ALUResult=0.
   - Undefined: MUL 3×5 → Done at accept+32, ALUResult=15.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with Start/Busy/Done handshake, iterative MUL and DIVU/REMU.
// Optional macro ALU_EARLY_TERM_EN lets MUL stop once the remaining multiplier bits are zero.
module alu_multicycle #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUResultHi,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_acc, r_sh, r_res, r_hi;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0] r_op;
  logic r_done, r_dbz;
  logic w_accept, w_div, w_dz, w_iter, w_fin, w_early, w_ok;
  logic [WIDTH-1:0] w_sres, w_acc_n, w_sh_n, w_res_n, w_hi_n;
  logic [WIDTH:0] w_sum, w_dif;
  logic [2*WIDTH-1:0] w_prod;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = r_state == IDLE ? ((w_accept && w_iter) ? CALC : IDLE) : (w_fin ? IDLE : CALC);
  always_comb begin
    w_accept = Start && r_state == IDLE;
    w_div = ALUControl[1:0] == 2'b11;
    w_dz = w_div && SrcB == '0;
    w_iter = ALUControl == 3'b101 || (w_div && !w_dz);
    w_sum = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_a} : '0);
    w_dif = {r_acc, r_sh[WIDTH-1]} - {1'b0, r_a};
    w_ok = !w_dif[WIDTH];
    w_acc_n = r_op == 3'b101 ? w_sum[WIDTH:1] : (w_ok ? w_dif[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_sh[WIDTH-1]});
    w_sh_n = r_op == 3'b101 ? {w_sum[0], r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], w_ok};
`ifdef ALU_EARLY_TERM_EN
    // product sits left-aligned until all WIDTH bits have been shifted through
    w_early = r_op == 3'b101 && ((r_sh >> 1) & ({WIDTH{1'b1}} >> (r_cnt + 1'b1))) == '0;
    w_prod = {w_acc_n, w_sh_n} >> (CNT_W'(WIDTH - 1) - r_cnt);
`else
    w_early = 1'b0;
    w_prod = {w_acc_n, w_sh_n};
`endif
    w_fin = r_state == CALC && (r_cnt == CNT_W'(WIDTH - 1) || w_early);
    w_res_n = r_op == 3'b101 ? w_prod[WIDTH-1:0] : (r_op == 3'b011 ? w_sh_n : w_acc_n);
    w_hi_n = r_op == 3'b101 ? w_prod[2*WIDTH-1:WIDTH] : '0;
  end
  always_comb begin
    case (ALUControl)
      3'b000:  w_sres = SrcA & SrcB;
      3'b001:  w_sres = SrcA | SrcB;
      3'b010:  w_sres = SrcA + SrcB;
      3'b100:  w_sres = SrcA - SrcB;
      3'b110:  w_sres = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      3'b011:  w_sres = '1;
      3'b111:  w_sres = SrcA;
      default: w_sres = '0;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_a <= '0;
      r_acc <= '0;
      r_sh <= '0;
      r_res <= '0;
      r_hi <= '0;
      r_cnt <= '0;
      r_op <= '0;
      r_done <= 1'b0;
      r_dbz <= 1'b0;
    end else begin
      r_done <= w_accept ? !w_iter : w_fin;
      if (w_accept) begin
        r_op <= ALUControl;
        r_cnt <= '0;
        r_acc <= '0;
        r_a <= w_div ? SrcB : SrcA;
        r_sh <= w_div ? SrcA : SrcB;
        r_dbz <= w_dz;
        if (!w_iter) begin
          r_res <= w_sres;
          r_hi <= '0;
        end
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_n;
        r_sh <= w_sh_n;
        if (w_fin) begin
          r_res <= w_res_n;
          r_hi <= w_hi_n;
        end
      end
    end
  assign ALUResult = r_res;
  assign ALUResultHi = r_hi;
  assign Zero = r_res == '0;
  assign Busy = r_state == CALC;
  assign Done = r_done;
  assign DivByZero = r_dbz;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;
  localparam int W = 32;
  logic CLK, RST, Start, Zero, Busy, Done, DivByZero;
  logic [W-1:0] SrcA, SrcB, ALUResult, ALUResultHi;
  logic [2:0] ALUControl;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic d;
    int lat;
    int acc;
  } exp_t;
  exp_t q[$];

  alu_multicycle #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .ALUResultHi(ALUResultHi), .Zero(Zero), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  function automatic int mul_lat(input logic [W-1:0] b);
`ifdef ALU_EARLY_TERM_EN
    int k = 1;
    for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
    return k;
`else
    return W;
`endif
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    e.h = '0; e.d = 1'b0; e.lat = 0; e.acc = 0;
    case (op)
      3'd0: e.r = a & b;
      3'd1: e.r = a | b;
      3'd2: e.r = a + b;
      3'd4: e.r = a - b;
      3'd6: e.r = (a < b) ? 1 : 0;
      3'd5: begin
        p = 64'(a) * 64'(b);
        e.r = p[31:0]; e.h = p[63:32]; e.lat = mul_lat(b);
      end
      3'd3: if (b == 0) begin e.r = '1; e.d = 1; end else begin e.r = a / b; e.lat = W; end
      default: if (b == 0) begin e.r = a; e.d = 1; end else begin e.r = a % b; e.lat = W; end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int n = 0;
    while (Busy && n < 100) begin
      Start = 1'($urandom); ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
      @(negedge CLK);
      n++;
    end
    if (Busy) chk("busy_timeout", 1, 0);
    Start = 1; ALUControl = op; SrcA = a; SrcB = b;
    e = model(op, a, b);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge CLK);
    Start = 0; ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST && Done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done got res=%h required no Done", ALUResult);
      end else begin
        e = q.pop_front();
        chk("result", ALUResult, e.r);
        chk("result_hi", ALUResultHi, e.h);
        chk("divbyzero", DivByZero, e.d);
        chk("zero", Zero, e.r == 0);
        chk("latency", cyc - e.acc, e.lat);
        chk("busy_at_done", Busy, 0);
      end
    end
  end

  initial begin
    logic [W-1:0] rb, a, b;
    int n;
`ifdef ALU_EARLY_TERM_EN
    rb = 32'h8000_0007;
`else
    rb = 7;
`endif
    RST = 0; Start = 0; ALUControl = 0; SrcA = 0; SrcB = 0;
    repeat (2) @(negedge CLK);
    chk("rst_result", ALUResult, 0);
    chk("rst_hi", ALUResultHi, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_dbz", DivByZero, 0);
    chk("rst_zero", Zero, 1);
    RST = 1;
    issue(3'd5, 5, rb);
    repeat (9) @(negedge CLK);
    chk("pre_abort_busy", Busy, 1);
    RST = 0;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_result", ALUResult, 0);
    chk("abort_zero", Zero, 1);
    chk("abort_done", Done, 0);
    q.delete();
    @(negedge CLK);
    RST = 1;
    issue(3'd2, 3, 4);
    issue(3'd4, 5, 5);
    issue(3'd6, 32'hFFFF_FFFF, 1);
    issue(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge CLK);
    Start = 1; ALUControl = 3'd2; SrcA = 1; SrcB = 2;
    @(negedge CLK);
    Start = 0;
    issue(3'd3, 100, 7);
    issue(3'd7, 100, 7);
    issue(3'd3, 9, 0);
    issue(3'd7, 9, 0);
    issue(3'd5, 3, 5);
    issue(3'd5, 3, 0);
    for (int i = 0; i < 250; i++) begin
      a = ($urandom % 3 == 0) ? $urandom_range(0, 300) : $urandom;
      case ($urandom % 4)
        0: b = 0;
        1: b = $urandom_range(1, 300);
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      issue(3'($urandom), a, b);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_pending", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
